// File: rtl/tile_pkg.sv
// Shared definitions for the tile board renderer: tile word fields,
// colour constants, the face palette and the renderer state encoding.
package tile_pkg;

   // Tile word layout: {id[5:0], face_up, cursor}
   localparam int ID_MSB     = 7;
   localparam int ID_LSB     = 2;
   localparam int FLIP_BIT   = 1;
   localparam int CURSOR_BIT = 0;

   localparam logic [8:0] BACK_COLOUR   = 9'o007;
   localparam logic [8:0] CURSOR_COLOUR = 9'o777;

   // Face palette indexed by id[2:0]; entry 7 is leftmost in the literal.
   localparam logic [7:0][8:0] PALETTE = {
      9'o777, 9'o474, 9'o740, 9'o077, 9'o707, 9'o770, 9'o070, 9'o700
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WAIT,
      ST_DRAW,
      ST_DONE
   } state_t;

endpackage

// File: rtl/tile_board_renderer_if.sv
// Bus between the renderer, the tile RAM spare read port and the VGA
// adapter pixel-write port. The renderer uses the slave view.
interface tile_board_renderer_if;
   logic       start;
   logic [3:0] addr;
   logic [7:0] rdata;
   logic [7:0] x;
   logic [6:0] y;
   logic [8:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (
      output start, rdata,
      input  addr, x, y, colour, plot, busy, done
   );

   modport slave (
      input  start, rdata,
      output addr, x, y, colour, plot, busy, done
   );
endinterface

// File: rtl/tile_raster_counter.sv
// Walks (px, py) over a TILE_PX x TILE_PX square in raster order,
// px fastest. i_start rewinds to (0,0); o_last flags the final pixel.
module tile_raster_counter #(
   parameter int TILE_PX = 20
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_start,
   input  logic       i_en,
   output logic [4:0] o_px,
   output logic [4:0] o_py,
   output logic       o_last
);
   localparam logic [4:0] LAST = 5'(TILE_PX - 1);

   logic [4:0] r_px;
   logic [4:0] r_py;

   // Raster position: rewind on start, advance one pixel per enabled cycle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_px <= '0;
         r_py <= '0;
      end else if (i_start) begin
         r_px <= '0;
         r_py <= '0;
      end else if (i_en) begin
         if (r_px == LAST) begin
            r_px <= '0;
            r_py <= (r_py == LAST) ? 5'd0 : r_py + 5'd1;
         end else begin
            r_px <= r_px + 5'd1;
         end
      end
   end

   assign o_px   = r_px;
   assign o_py   = r_py;
   assign o_last = (r_px == LAST) && (r_py == LAST);
endmodule

// File: rtl/tile_board_renderer.sv
// Repaints the 4x4 tile board from the tile RAM into the VGA pixel port.
// Optional feature macro: TILE_CURSOR_OUTLINE_EN draws a two-pixel white
// outline on tiles whose cursor bit is set.
module tile_board_renderer
   import tile_pkg::*;
#(
   parameter int TILE_PX  = 20,
   parameter int GAP      = 4,
   parameter int ORIGIN_X = 32,
   parameter int ORIGIN_Y = 12,
   parameter int READ_LAT = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   tile_board_renderer_if.slave  bus
);
   localparam logic [7:0] WAIT_LAST = 8'(READ_LAT - 1);
   localparam logic [8:0] PITCH     = 9'(TILE_PX + GAP);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_k;
   logic [7:0] r_wait;
   logic [7:0] r_tile;
   logic [4:0] w_px;
   logic [4:0] w_py;
   logic       w_last;
   logic       w_raster_start;
   logic       w_plot;
   logic       w_busy;
   logic       w_done;
   logic [8:0] w_x9;
   logic [8:0] w_y9;
   logic [8:0] w_face;
   logic [8:0] w_colour;
   logic       w_unused;

   tile_raster_counter #(.TILE_PX(TILE_PX)) u_raster (
      .clk     (clk),
      .resetn  (resetn),
      .i_start (w_raster_start),
      .i_en    (w_plot),
      .o_px    (w_px),
      .o_py    (w_py),
      .o_last  (w_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // Next-state and control outputs
   always_comb begin
      w_next         = r_state;
      w_plot         = 1'b0;
      w_busy         = 1'b0;
      w_done         = 1'b0;
      w_raster_start = 1'b0;
      unique case (r_state)
         ST_IDLE: if (bus.start) w_next = ST_ADDR;
         ST_ADDR: begin
            w_busy = 1'b1;
            w_next = ST_WAIT;
         end
         ST_WAIT: begin
            w_busy = 1'b1;
            if (r_wait == WAIT_LAST) begin
               w_next         = ST_DRAW;
               w_raster_start = 1'b1;
            end
         end
         ST_DRAW: begin
            w_busy = 1'b1;
            w_plot = 1'b1;
            if (w_last) w_next = (r_k == 4'd15) ? ST_DONE : ST_ADDR;
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Tile index and read-latency counter
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_k    <= '0;
         r_wait <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.start) r_k <= '0;
            ST_ADDR: r_wait <= '0;
            ST_WAIT: r_wait <= r_wait + 8'd1;
            ST_DRAW: if (w_last && r_k != 4'd15) r_k <= r_k + 4'd1;
            default: ;
         endcase
      end
   end

   // Capture the tile word once the RAM read has settled
   always_ff @(posedge clk) begin
      if (w_raster_start) r_tile <= bus.rdata;
   end

   assign w_x9   = 9'(ORIGIN_X) + 9'(r_k[1:0]) * PITCH + 9'(w_px);
   assign w_y9   = 9'(ORIGIN_Y) + 9'(r_k[3:2]) * PITCH + 9'(w_py);
   assign w_face = r_tile[FLIP_BIT] ? PALETTE[r_tile[ID_LSB+2:ID_LSB]] : BACK_COLOUR;

`ifdef TILE_CURSOR_OUTLINE_EN
   localparam logic [4:0] EDGE_HI = 5'(TILE_PX - 2);
   logic w_outline;
   assign w_outline = (w_px < 5'd2) || (w_px >= EDGE_HI) ||
                      (w_py < 5'd2) || (w_py >= EDGE_HI);
   assign w_colour  = (r_tile[CURSOR_BIT] && w_outline) ? CURSOR_COLOUR : w_face;
   assign w_unused  = &{1'b0, r_tile[ID_MSB:ID_LSB+3], w_x9[8], w_y9[8:7]};
`else
   assign w_colour  = w_face;
   assign w_unused  = &{1'b0, r_tile[ID_MSB:ID_LSB+3], r_tile[CURSOR_BIT],
                        w_x9[8], w_y9[8:7]};
`endif

   // Pixel outputs are forced to zero outside DRAW so reset values hold
   assign bus.addr   = r_k;
   assign bus.plot   = w_plot;
   assign bus.busy   = w_busy;
   assign bus.done   = w_done;
   assign bus.x      = w_plot ? w_x9[7:0] : 8'd0;
   assign bus.y      = w_plot ? w_y9[6:0] : 7'd0;
   assign bus.colour = w_plot ? w_colour  : 9'd0;
endmodule

// File: tb/tb_tile_board_renderer.sv
// Scoreboard bench for tile_board_renderer: frames are queued as expected
// pixel streams and a monitor pops/compares on every plot strobe.
module tb_tile_board_renderer;
   localparam int TILE_PX   = 20;
   localparam int GAP       = 4;
   localparam int OX        = 32;
   localparam int OY        = 12;
   localparam int READ_LAT  = 2;
   localparam int FRAME_PIX = 6400;
   localparam int FRAME_CYC = 6448;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   tile_board_renderer_if bus();

   tile_board_renderer #(
      .TILE_PX(TILE_PX), .GAP(GAP), .ORIGIN_X(OX), .ORIGIN_Y(OY), .READ_LAT(READ_LAT)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Tile RAM model with READ_LAT = 2 pipeline
   logic [7:0] mem [16];
   logic [7:0] rd_p1, rd_p2;
   always @(posedge clk) begin
      rd_p1 <= mem[bus.addr];
      rd_p2 <= rd_p1;
   end
   assign bus.rdata = rd_p2;

   logic [23:0] exp_q [$];
   logic [8:0]  scr [160][120];
   int n_chk = 0, n_err = 0;
   int cyc = 0, plot_total = 0, busy_total = 0, done_total = 0;
   int last_plot_cyc = 0, last_done_cyc = 0, first_plot_cyc = 0;
   bit arm = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] pal(input logic [2:0] i);
      case (i)
         3'd0: pal = 9'o700;  3'd1: pal = 9'o070;
         3'd2: pal = 9'o770;  3'd3: pal = 9'o707;
         3'd4: pal = 9'o077;  3'd5: pal = 9'o740;
         3'd6: pal = 9'o474;  default: pal = 9'o777;
      endcase
   endfunction

   function automatic logic [8:0] exp_colour(input logic [7:0] w, input int px, input int py);
      logic [8:0] c;
      c = w[1] ? pal(w[4:2]) : 9'o007;
`ifdef TILE_CURSOR_OUTLINE_EN
      if (w[0] && (px < 2 || px >= TILE_PX-2 || py < 2 || py >= TILE_PX-2)) c = 9'o777;
`endif
      return c;
   endfunction

   task automatic push_frame();
      for (int k = 0; k < 16; k++)
         for (int py = 0; py < TILE_PX; py++)
            for (int px = 0; px < TILE_PX; px++) begin
               logic [7:0] xx;
               logic [6:0] yy;
               xx = 8'(OX + (k % 4) * (TILE_PX + GAP) + px);
               yy = 7'(OY + (k / 4) * (TILE_PX + GAP) + py);
               exp_q.push_back({xx, yy, exp_colour(mem[k], px, py)});
            end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.busy) busy_total++;
         if (bus.done) begin
            done_total++;
            last_done_cyc = cyc;
         end
         if (bus.plot) begin
            plot_total++;
            last_plot_cyc = cyc;
            if (arm) begin
               first_plot_cyc = cyc;
               arm = 0;
            end
            if (bus.x < 8'd160 && bus.y < 7'd120) scr[bus.x][bus.y] = bus.colour;
            if (exp_q.size() == 0) chk("unexpected_plot", 1, 0);
            else chk("pixel", {bus.x, bus.y, bus.colour}, exp_q.pop_front());
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue one start; optionally pulse start again restart_at cycles later.
   task automatic run_frame(input int restart_at);
      int bp, bb, bd, ce, n;
      bp = plot_total; bb = busy_total; bd = done_total;
      push_frame();
      bus.start = 1'b1;
      arm = 1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      ce = cyc;
      @(negedge clk);
      chk("busy_rise", bus.busy, 1);
      chk("addr_first", bus.addr, 0);
      @(posedge clk);
      #1;
      n = 0;
      while (done_total == bd && n < 7000) begin
         if (restart_at > 0 && n == restart_at) bus.start = 1'b1;
         else bus.start = 1'b0;
         step(1);
         n++;
      end
      bus.start = 1'b0;
      if (done_total == bd) chk("done_timeout", 0, 1);
      step(3);
      chk("first_plot_latency", first_plot_cyc - ce, 2 + READ_LAT);
      chk("plot_count", plot_total - bp, FRAME_PIX);
      chk("busy_cycles", busy_total - bb, FRAME_CYC);
      chk("done_pulses", done_total - bd, 1);
      chk("done_after_last_plot", last_done_cyc, last_plot_cyc + 1);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      int bp, bb, n;
      fork
         monitor();
      join_none
      bus.start = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;

      // Reset values
      resetn = 1'b0;
      step(3);
      chk("rst_addr", bus.addr, 0);
      chk("rst_x", bus.x, 0);
      chk("rst_y", bus.y, 0);
      chk("rst_colour", bus.colour, 0);
      chk("rst_plot", bus.plot, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      resetn = 1'b1;
      bp = plot_total; bb = busy_total;
      step(100);
      chk("idle_no_plot", plot_total - bp, 0);
      chk("idle_no_busy", busy_total - bb, 0);

      // All tiles face-down
      run_frame(0);
      chk("blank_tile0", scr[32][12], 9'o007);

      // Tile 5 face-up with id 3
      mem[5] = {6'd3, 2'b10};
      run_frame(0);
      chk("t5_topleft", scr[56][36], 9'o707);
      chk("t5_botright", scr[75][55], 9'o707);
      chk("t6_back", scr[80][36], 9'o007);
      chk("t4_back", scr[51][55], 9'o007);
      mem[5] = 8'h00;

      // Cursor on tile 0
      mem[0] = 8'h01;
      run_frame(0);
`ifdef TILE_CURSOR_OUTLINE_EN
      chk("cur_32_12", scr[32][12], 9'o777);
      chk("cur_33_13", scr[33][13], 9'o777);
`else
      chk("cur_32_12", scr[32][12], 9'o007);
      chk("cur_33_13", scr[33][13], 9'o007);
`endif
      chk("cur_34_14", scr[34][14], 9'o007);
      mem[0] = 8'h00;

      // Reset during tile 7 DRAW
      bp = plot_total;
      push_frame();
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      n = 0;
      while (plot_total - bp < 7 * 400 + 10 && n < 4000) begin
         step(1);
         n++;
      end
      chk("reach_tile7", (plot_total - bp >= 7 * 400 + 10) ? 1 : 0, 1);
      resetn = 1'b0;
      step(1);
      chk("midrst_plot", bus.plot, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_addr", bus.addr, 0);
      chk("midrst_xycol", {bus.x, bus.y, bus.colour}, 0);
      exp_q.delete();
      resetn = 1'b1;
      bp = plot_total; bb = busy_total;
      step(20);
      chk("postrst_idle_plot", plot_total - bp, 0);
      chk("postrst_idle_busy", busy_total - bb, 0);
      run_frame(0);

      // Second start mid-frame is ignored
      run_frame(1000);
      bp = plot_total;
      step(20);
      chk("no_extra_frame", plot_total - bp, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
